// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  // Step-counter width for an arbitrary operand width.
  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift/subtract step of the divider.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted_s = {rem_in[WIDTH-1:0], bit_in};
    trial_s   = shifted_s - {1'b0, divisor};
    // A set bit shifted out of the top means the true value exceeds any divisor.
    q_bit     = rem_in[WIDTH] | ~trial_s[WIDTH];
    if (q_bit) begin
      rem_out = trial_s;
    end else begin
      rem_out = shifted_s;
    end
  end

endmodule

// File: rtl/div8_seq.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Optional two's-complement operation when DIV_SIGNED_EN is defined.
module div8_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       state_r, state_nx_s;
  logic             accept_s, zero_div_s, last_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dvd_r, dsr_r;
  logic [WIDTH:0]   prem_r, rem_nx_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] q_raw_s, r_raw_s, q_fix_s, r_fix_s;
  logic [WIDTH-1:0] dvd_cap_s, dsr_cap_s;
  logic             busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  assign zero_div_s = (divisor == {WIDTH{1'b0}});
  assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));
  assign q_raw_s    = {dvd_r[WIDTH-2:0], q_bit_s};
  assign r_raw_s    = rem_nx_s[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .divisor (dsr_r),
    .rem_out (rem_nx_s),
    .q_bit   (q_bit_s)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_r, neg_r_r;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitudes feed the unsigned datapath; signs are reapplied on the way out.
  always_comb begin
    dvd_cap_s = dividend[WIDTH-1] ? negate(dividend) : dividend;
    dsr_cap_s = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
    q_fix_s   = neg_q_r ? negate(q_raw_s) : q_raw_s;
    r_fix_s   = neg_r_r ? negate(r_raw_s) : r_raw_s;
  end

  // Result sign flags captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_r <= dividend[WIDTH-1];
    end else begin
      neg_q_r <= neg_q_r;
      neg_r_r <= neg_r_r;
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    dvd_cap_s = dividend;
    dsr_cap_s = divisor;
    q_fix_s   = q_raw_s;
    r_fix_s   = r_raw_s;
  end
`endif

  // State register with registered busy/done derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == ST_RUN);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  // Next-state logic; a start is honoured in IDLE and DONE only.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = zero_div_s ? ST_DONE : ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dsr_r       <= {WIDTH{1'b0}};
      prem_r      <= {(WIDTH+1){1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else if (accept_s) begin
      if (zero_div_s) begin
        quotient_r  <= {WIDTH{1'b1}};
        remainder_r <= dividend;
        dbz_r       <= 1'b1;
      end else begin
        dvd_r  <= dvd_cap_s;
        dsr_r  <= dsr_cap_s;
        prem_r <= {(WIDTH+1){1'b0}};
        cnt_r  <= {CNT_W{1'b0}};
      end
    end else if (state_r == ST_RUN) begin
      prem_r <= rem_nx_s;
      dvd_r  <= q_raw_s;
      cnt_r  <= cnt_r + CNT_W'(1);
      if (last_s) begin
        quotient_r  <= q_fix_s;
        remainder_r <= r_fix_s;
        dbz_r       <= 1'b0;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed scenarios plus randomized operands
// checked against an arithmetic reference model.
module tb_div8_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] last_q;

  div8_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands.
  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz);
`ifdef DIV_SIGNED_EN
    int sa, sb;
`endif
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q = 8'(sa / sb);
      r = 8'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      dz = 1'b0;
    end
  endtask

  // Issue one operation; lat = negedges after the accepting edge until done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      bcnt += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, quotient, remainder, div_by_zero});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [7:0] eq, er; logic ed;
    ref_div(8'd100, 8'd7, eq, er, ed);
    do_op(8'd100, 8'd7, lat, bcnt);
    nvec++;
    if (lat !== 8 || bcnt !== 8 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL basic_timing: lat=%0d busy_cycles=%0d busy=%b expected 8/8/0", lat, bcnt, busy);
    end
    nvec++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, ed} || eq !== 8'd14 || er !== 8'd2) begin
      nerr++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
               quotient, remainder, div_by_zero, eq, er, ed);
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || quotient !== eq) begin
      nerr++;
      $display("FAIL basic_done_pulse: done=%b q=%0d expected done=0 q=%0d", done, quotient, eq);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    do_op(8'd55, 8'd0, lat, bcnt);
    nvec++;
    if (lat !== 0 || bcnt !== 0) begin
      nerr++;
      $display("FAIL divzero_timing: lat=%0d busy_cycles=%0d expected 0/0", lat, bcnt);
    end
    nvec++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd55, 1'b1}) begin
      nerr++;
      $display("FAIL divzero_result: got q=%0d r=%0d dz=%b expected 255 55 1",
               quotient, remainder, div_by_zero);
    end
    last_q = 8'd255;
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [7:0] eq, er; logic ed;
    ref_div(8'd200, 8'd10, eq, er, ed);
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd10;
    @(negedge clk);
    dividend = 8'd9; divisor = 8'd3;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2) begin
        nvec++;
        if (quotient !== last_q || div_by_zero !== 1'b1) begin
          nerr++;
          $display("FAIL result_hold: q=%0d dz=%b expected q=%0d dz=1", quotient, div_by_zero, last_q);
        end
      end
      if (lat >= 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    nvec++;
    if (lat !== 8 || {quotient, remainder, div_by_zero} !== {eq, er, ed}) begin
      nerr++;
      $display("FAIL start_ignored: lat=%0d q=%0d r=%0d dz=%b expected lat=8 q=%0d r=%0d dz=%b",
               lat, quotient, remainder, div_by_zero, eq, er, ed);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [7:0] eq, er; logic ed;
    ref_div(8'd255, 8'd16, eq, er, ed);
    do_op(8'd255, 8'd16, lat, bcnt);
    nvec++;
    if (lat !== 8 || {quotient, remainder, div_by_zero} !== {eq, er, ed}) begin
      nerr++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d expected lat=8 q=%0d r=%0d", lat, quotient, remainder, eq, er);
    end
    start = 1'b1; dividend = 8'd8; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_handover: done=%b busy=%b expected 0 1", done, busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ref_div(8'd8, 8'd3, eq, er, ed);
    nvec++;
    if (lat !== 8 || {quotient, remainder, div_by_zero} !== {eq, er, ed}) begin
      nerr++;
      $display("FAIL b2b_second: lat=%0d q=%0d r=%0d expected lat=8 q=%0d r=%0d", lat, quotient, remainder, eq, er);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      nerr++;
      $display("FAIL midrun_reset: got %h expected 0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL midrun_no_done: done seen=%b expected 0", seen);
    end
    do_op(8'd1, 8'd1, lat, bcnt);
    nvec++;
    if (lat !== 8 || {quotient, remainder, div_by_zero} !== {8'd1, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL midrun_recover: lat=%0d q=%0d r=%0d expected lat=8 q=1 r=0", lat, quotient, remainder);
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [7:0] a, b, eq, er; logic ed;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
      ref_div(a, b, eq, er, ed);
      do_op(a, b, lat, bcnt);
      nvec++;
      if (lat !== (ed ? 0 : 8) || {quotient, remainder, div_by_zero} !== {eq, er, ed}) begin
        nerr++;
        $display("FAIL random_%0d: %0d/%0d lat=%0d q=%0d r=%0d dz=%b expected lat=%0d q=%0d r=%0d dz=%b",
                 i, a, b, lat, quotient, remainder, div_by_zero, ed ? 0 : 8, eq, er, ed);
      end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bcnt;
    do_op(8'h9C, 8'd7, lat, bcnt);
    nvec++;
    if ({quotient, remainder} !== {8'hF2, 8'hFE}) begin
      nerr++;
      $display("FAIL signed_neg_dividend: q=%h r=%h expected f2 fe", quotient, remainder);
    end
    do_op(8'd100, 8'hF9, lat, bcnt);
    nvec++;
    if ({quotient, remainder} !== {8'hF2, 8'h02}) begin
      nerr++;
      $display("FAIL signed_neg_divisor: q=%h r=%h expected f2 02", quotient, remainder);
    end
    do_op(8'h80, 8'hFF, lat, bcnt);
    nvec++;
    if ({quotient, remainder} !== {8'h80, 8'h00}) begin
      nerr++;
      $display("FAIL signed_min_by_m1: q=%h r=%h expected 80 00", quotient, remainder);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
